// File: rtl/cpu_pkg.sv
// Shared types for the CPU controller slice.
//   opcode_t : 3-bit instruction opcode, also used by the ALU
//   phase_t  : the eight instruction phases, in counting order
//   is_aluop : true for opcodes that read an operand and load the accumulator
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    function automatic logic is_aluop(input opcode_t op);
        return op inside {ADD, AND, XOR, LDA};
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Phase sequencer for the CPU controller.
// Steps INST_ADDR..STORE once per clock and wraps. A HLT request (raised by the
// decoder in OP_ADDR) sets the sticky halted flag, which freezes the phase at
// OP_ADDR until rst.
// Optional feature (macro CPU_CTRL_STEP_EN): with step_mode=1 the counter waits
// in INST_ADDR for a step pulse, then runs exactly one instruction.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   hlt_req           HLT decoded in OP_ADDR this cycle
//   step, step_mode   single-step controls (CPU_CTRL_STEP_EN only)
//   phase             current phase
//   halted            halted state
module cpu_phase_counter
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hlt_req,
`ifdef CPU_CTRL_STEP_EN
    input  logic   step,
    input  logic   step_mode,
`endif
    output phase_t phase,
    output logic   halted
);

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   advance;

    always_comb begin
`ifdef CPU_CTRL_STEP_EN
        // Only INST_ADDR is gated, so a started instruction always completes.
        advance = !step_mode || (phase_q != INST_ADDR) || step;
`else
        advance = 1'b1;
`endif
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (hlt_req) begin
                halted_d = 1'b1;
            end else if (advance) begin
                phase_d = phase_t'(phase_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign phase  = phase_q;
    assign halted = halted_q;

endmodule

// File: rtl/cpu_controller.sv
// CPU control unit: decodes the registered phase, opcode and zero flag into
// the datapath strobes with no added latency.
// Optional feature: define CPU_CTRL_STEP_EN to add step/step_mode inputs for
// single-instruction stepping.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   opcode        instruction opcode (OPCODE_W bits, only 3 supported)
//   zero          ALU accumulator-is-zero flag, used in ALU_OP only
//   sel           address mux select (1 = PC, 0 = IR operand)
//   rd, wr        memory read / write
//   ld_ir, ld_ac, ld_pc, inc_pc   register load / increment strobes
//   halt          processor halted
//   data_e        accumulator drives the data bus
//   phase         current phase, for debug
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
`ifdef CPU_CTRL_STEP_EN
    input  logic                step,
    input  logic                step_mode,
`endif
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                wr,
    output logic                data_e,
    output logic [2:0]          phase
);

    opcode_t op;
    phase_t  phase_cur;
    logic    halted;
    logic    aluop;
    logic    hlt_req;

    assign op      = opcode_t'(opcode);
    assign aluop   = is_aluop(op);
    assign hlt_req = (phase_cur == OP_ADDR) && (op == HLT);

    cpu_phase_counter u_phase_counter (
        .clk       (clk),
        .rst       (rst),
        .hlt_req   (hlt_req),
`ifdef CPU_CTRL_STEP_EN
        .step      (step),
        .step_mode (step_mode),
`endif
        .phase     (phase_cur),
        .halted    (halted)
    );

    assign phase = phase_cur;

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            unique case (phase_cur)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    // PC still increments in the cycle HLT is decoded.
                    inc_pc = 1'b1;
                    halt   = (op == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (op == SKZ) && zero;
                    ld_pc  = (op == JMP);
                    data_e = (op == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (op == JMP);
                    data_e = (op == STO);
                    wr     = (op == STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: a phase/halt model with a rule-based
// output table checked every negedge, plus directed sequences with literal
// expectations. Define CPU_CTRL_STEP_EN to also exercise single-stepping.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    logic       step = 1'b0;
    logic       step_mode = 1'b0;
`endif
    logic sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;

    // Bit positions inside the packed output vector.
    localparam int B_SEL = 8, B_RD = 7, B_LDIR = 6, B_HALT = 5, B_INC = 4;
    localparam int B_LDAC = 3, B_LDPC = 2, B_WR = 1, B_DE = 0;

    logic [11:0] dut_vec;
    assign dut_vec = {phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

    cpu_controller #(.OPCODE_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
`ifdef CPU_CTRL_STEP_EN
        .step      (step),
        .step_mode (step_mode),
`endif
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .halt      (halt),
        .inc_pc    (inc_pc),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .wr        (wr),
        .data_e    (data_e),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int m_phase  = 0;
    bit m_halted = 1'b0;

    function automatic bit m_advance();
`ifdef CPU_CTRL_STEP_EN
        return !step_mode || m_phase != 0 || step;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && opcode == 3'd0) m_halted <= 1'b1;
            else if (m_advance()) m_phase <= (m_phase + 1) % 8;
        end
    end

    function automatic logic [11:0] expect_out(input int ph, input bit hs,
                                                input logic [2:0] op, input logic z);
        bit alu;
        logic [2:0] p;
        alu = op inside {3'b010, 3'b011, 3'b100, 3'b101};
        p   = ph[2:0];
        if (hs) return {3'd4, 9'b0_0_0_1_0_0_0_0_0};
        return {p,
                ph <= 3,                                   // sel
                (ph >= 1 && ph <= 3) || (ph >= 5 && alu),  // rd
                ph == 2 || ph == 3,                        // ld_ir
                ph == 4 && op == 3'd0,                     // halt
                ph == 4 || (ph == 6 && op == 3'd1 && z),   // inc_pc
                ph == 7 && alu,                            // ld_ac
                ph >= 6 && op == 3'd7,                     // ld_pc
                ph == 7 && op == 3'd6,                     // wr
                ph >= 6 && op == 3'd6};                    // data_e
    endfunction

    always @(negedge clk) begin
        logic [11:0] e;
        e = expect_out(m_phase, m_halted, opcode, zero);
        checks++;
        if (dut_vec !== e) begin
            errors++;
            $display("FAIL model_cmp t=%0t op=%0d: got %b expected %b",
                     $time, opcode, dut_vec, e);
        end
    end

    // ---------------- directed helpers ----------------
    logic [11:0] obs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ends 1 time unit after a posedge, with rst released and phase 0.
    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_outputs", {20'd0, dut_vec}, {20'd0, 3'd0, 9'b1_0000_0000});
        rst = 1'b0;
    endtask

    task automatic run(input int n, input logic [2:0] op, input logic [7:0] zpat);
        for (int i = 0; i < n; i++) begin
            opcode = op;
            zero   = zpat[i];
            @(negedge clk);
            obs[i] = dut_vec;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] mask(input int b);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = obs[i][b];
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        #2;

        // ADD: full instruction, read/load pattern, wrap.
        reset_dut();
        run(8, 3'b010, 8'h00);
        chk("add_phase1", obs[1][11:9], 3'd1);
        chk("add_rd", mask(B_RD), 8'b1110_1110);
        chk("add_ld_ac", mask(B_LDAC), 8'b1000_0000);
        chk("add_sel", mask(B_SEL), 8'b0000_1111);
        chk("add_ld_ir", mask(B_LDIR), 8'b0000_1100);
        chk("add_wrap", phase, 3'd0);

        // SKZ: zero honoured in phase 6 only.
        reset_dut();
        run(8, 3'b001, 8'b0100_0000);
        chk("skz_zero_ph6", mask(B_INC), 8'b0101_0000);
        reset_dut();
        run(8, 3'b001, 8'b0010_0000);
        chk("skz_zero_ph5", mask(B_INC), 8'b0001_0000);

        // STO.
        reset_dut();
        run(8, 3'b110, 8'h00);
        chk("sto_data_e", mask(B_DE), 8'b1100_0000);
        chk("sto_wr", mask(B_WR), 8'b1000_0000);
        chk("sto_rd", mask(B_RD), 8'b0000_1110);

        // HLT: decode cycle, frozen phase, reset recovery.
        reset_dut();
        run(5, 3'b000, 8'h00);
        chk("hlt_decode_halt", obs[4][B_HALT], 1'b1);
        chk("hlt_decode_inc", obs[4][B_INC], 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            opcode = 3'b010;
            zero   = i[0];
            @(negedge clk);
            if (dut_vec !== {3'd4, 9'b0_0_0_1_0_0_0_0_0}) bad++;
            @(posedge clk);
            #1;
        end
        chk("hlt_frozen_cycles_bad", bad, 0);
        rst = 1'b1;
        #1;
        chk("hlt_rst_phase", phase, 3'd0);
        chk("hlt_rst_halt", halt, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // JMP with asynchronous reset in phase 6.
        reset_dut();
        run(6, 3'b111, 8'h00);
        chk("jmp_ld_pc_ph6", ld_pc, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("jmp_async_ld_pc", ld_pc, 1'b0);
        chk("jmp_async_phase", phase, 3'd0);
        chk("jmp_async_sel", sel, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sweep non-halting opcodes; the model compare covers every cycle.
        reset_dut();
        for (int op = 1; op < 8; op++) begin
            logic [2:0] o;
            o = op[2:0];
            run(8, o, (op % 2 == 1) ? 8'hFF : 8'h55);
        end

`ifdef CPU_CTRL_STEP_EN
        begin
            int adv;
            logic [2:0] prev;
            step_mode = 1'b1;
            reset_dut();
            run(3, 3'b010, 8'h00);
            chk("step_hold", {obs[0][11:9], obs[1][11:9], obs[2][11:9]}, 9'd0);
            step = 1'b1;
            adv  = 0;
            for (int i = 0; i < 14; i++) begin
                prev = phase;
                @(posedge clk);
                #1;
                step = 1'b0;
                if (phase !== prev) adv++;
            end
            chk("step_advances", adv, 8);
            chk("step_end_phase", phase, 3'd0);
            chk("step_end_rd", rd, 1'b0);
            step_mode = 1'b0;
        end
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have exactly one parameter, listed below.
REQ-002 OPCODE_W, 3, SHALL set the opcode width; only 3 is supported.
REQ-003 Ports SHALL be as listed below; there is one clock, and reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 opcode  input  OPCODE_W  instruction opcode from the instruction register; the ALU receives the same value.
REQ-007 zero  input  1  ALU is_zero flag (accumulator == 0).
REQ-008 sel  output  1  address mux select: 1 = PC, 0 = IR operand.
REQ-009 rd  output  1  memory read enable.
REQ-010 ld_ir  output  1  instruction register load.
REQ-011 halt  output  1  processor halted.
REQ-012 inc_pc  output  1  PC increment.
REQ-013 ld_ac  output  1  accumulator load from ALU res.
REQ-014 ld_pc  output  1  PC load from IR operand.
REQ-015 wr  output  1  memory write.
REQ-016 data_e  output  1  accumulator drives the data bus.
REQ-017 phase  output  3  current phase, for debug.

Function
REQ-018 A 3-bit phase counter SHALL step once per clk through INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), then wrap from 7 to 0.
REQ-019 ALUOP is defined as opcode in {ADD=010, AND=011, XOR=100, LDA=101}.
REQ-020 All outputs SHALL be combinational decodes of the registered phase, opcode and zero, with zero cycles of added latency.
REQ-021 sel SHALL be 1 in phases 0-3.
REQ-022 rd SHALL be 1 in phases 1-3, and in phases 5-7 when ALUOP.
REQ-023 ld_ir SHALL be 1 in phases 2-3.
REQ-024 inc_pc SHALL be 1 in phase 4, and in phase 6 when opcode==SKZ(001) and zero==1.
REQ-025 ld_ac SHALL be 1 in phase 7 when ALUOP.
REQ-026 ld_pc SHALL be 1 in phases 6-7 when opcode==JMP(111).
REQ-027 data_e SHALL be 1 in phases 6-7 when opcode==STO(110).
REQ-028 wr SHALL be 1 in phase 7 when opcode==STO.
REQ-029 zero SHALL be sampled live in phase 6 only; changes in zero in any other phase SHALL have no effect.
REQ-030 In phase 4 with opcode==HLT(000), the block SHALL enter a HALTED state: halt=1, phase frozen at 4, and every other output 0 from the next cycle on.
REQ-031 The HALTED state SHALL be left only through rst.
REQ-032 During the single phase-4 cycle in which HLT is decoded, halt SHALL be 1 and inc_pc SHALL still be 1.
REQ-033 Outputs SHALL be 0 for every opcode/phase combination not listed in REQ-021 to REQ-028.

Reset
REQ-034 Asserting rst at any time, including mid-instruction or while HALTED, SHALL immediately force phase=0 and clear HALTED.
REQ-035 While in reset, outputs SHALL decode phase 0: sel=1 and all others 0.
REQ-036 The first rising clk edge after rst deasserts SHALL advance phase to 1.

Configuration
REQ-037 Macro CPU_CTRL_STEP_EN defined SHALL add input step (1 bit) and input step_mode (1 bit).
REQ-038 With CPU_CTRL_STEP_EN defined and step_mode=1, the phase counter SHALL hold at phase 0 until a cycle with step=1, and then complete exactly one full instruction (phases 0-7) before holding again.
REQ-039 With CPU_CTRL_STEP_EN defined and step_mode=0, behaviour SHALL be identical to the macro-undefined build.
REQ-040 With CPU_CTRL_STEP_EN undefined, the step and step_mode ports SHALL NOT exist and the counter SHALL free-run.

Structure
REQ-041 Package cpu_pkg SHALL hold the opcode enum (HLT..JMP, 3-bit), the phase enum (8 values), and the ALUOP membership function; the ALU shares the opcode enum.
REQ-042 Sub-module cpu_phase_counter SHALL hold the phase register, wrap, halt freeze and step gating.
REQ-043 The output decode SHALL reside in cpu_controller.

Verification
REQ-044 Reset, then opcode=ADD for 8 cycles -> rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; phase returns to 0 at cycle 8.
REQ-045 opcode=SKZ with zero=1 in phase 6 -> inc_pc=1 in phases 4 and 6; with zero=1 only in phase 5 -> inc_pc=1 in phase 4 only.
REQ-046 opcode=STO -> data_e=1 in phases 6-7, wr=1 in phase 7 only, rd=0 in phases 5-7.
REQ-047 opcode=HLT -> halt=1 from phase 4 onward, phase stays 4 for 20 cycles; rst pulse -> phase=0, halt=0.
REQ-048 opcode=JMP, rst asserted in phase 6 -> ld_pc drops asynchronously, phase=0, sel=1.
REQ-049 With CPU_CTRL_STEP_EN, step_mode=1 and a 1-cycle step pulse -> exactly 8 phase advances, then hold at phase 0 with rd=0.
